// File: rtl/dmem_pkg.sv
// Shared types and helpers for the parametrised data memory.
//   dmem_state_e : clear sequencer states (StClear zeroes the array, StReady serves requests)
//   even_parity  : even-parity bit of a word, zero-extended to PAR_MAX_W bits
package dmem_pkg;

  typedef enum logic {StClear, StReady} dmem_state_e;

  // Widest data word the parity helper accepts. Zero-extension leaves parity unchanged.
  localparam int unsigned PAR_MAX_W = 64;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/dmem_clear_seq.sv
// Clear sequencer for param_data_memory: walks clr_ptr over every word after reset or on
// clear_req, then parks in StReady.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear_req  : restart the clear sequence from word 0
//   clr_we     : write-zero enable for the array (high for the whole StClear state)
//   clr_addr   : word being zeroed this cycle
//   init_done  : registered, high while in StReady
module dmem_clear_seq
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  dmem_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StClear;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (clear_req) begin
            ptr_q <= '0;
          end else if (ptr_q == LAST) begin
            // Last word is zeroed on this edge; DEPTH cycles in total.
            state_q <= StReady;
            ptr_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        StReady: begin
          if (clear_req) begin
            state_q <= StClear;
            ptr_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StClear;
          ptr_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we    = (state_q == StClear);
  assign clr_addr  = ptr_q;
  assign init_done = done_q;

endmodule

// File: rtl/param_data_memory.sv
// Parametrised single-port data memory with valid/ready request port, one-cycle registered
// response and a hardware clear sequencer.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   clear_req           : restart the clear sequence
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_write           : 1 = write, 0 = read
//   req_addr, req_wdata : word address and write data
//   rsp_valid           : one-cycle pulse per accepted request
//   rsp_rdata, rsp_err  : read data (or echoed write data) and error flag; held when idle
//   err_inject          : store inverted parity on write (parity build only)
//   init_done           : high while ready to serve requests
// Optional feature: define DMEM_PARITY_EN to store and check an even-parity bit per word.
// Requires 1 <= DEPTH <= 2**ADDR_W; parity build requires DATA_W <= 64.
module param_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              err_inject,
  output logic              init_done
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic              rd_par_err;
  rsp_t              rsp_d, rsp_q;

  logic [DATA_W-1:0] mem [DEPTH];

  dmem_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  assign req_ready = init_done & ~clear_req;
  assign accept    = req_valid & req_ready;
  // Extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
  assign in_range  = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
  assign idx       = req_addr[IDX_W-1:0];
  assign rd_word   = mem[idx];

  // Clear and request writes never coincide: req_ready is low throughout StClear.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr[IDX_W-1:0]] <= '0;
    end else if (accept && req_write && in_range) begin
      mem[idx] <= req_wdata;
    end
  end

`ifdef DMEM_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par[clr_addr[IDX_W-1:0]] <= 1'b0;
    end else if (accept && req_write && in_range) begin
      par[idx] <= even_parity(PAR_MAX_W'(req_wdata)) ^ err_inject;
    end
  end

  assign rd_par_err = even_parity(PAR_MAX_W'(rd_word)) != par[idx];
`else
  logic unused_err_inject;
  assign unused_err_inject = err_inject;
  assign rd_par_err        = 1'b0;
`endif

  always_comb begin
    rsp_d       = rsp_q;
    rsp_d.valid = accept;
    if (accept) begin
      if (req_write) begin
        rsp_d.data = req_wdata;
      end else begin
        rsp_d.data = in_range ? rd_word : '0;
      end
      rsp_d.err = ~in_range | (~req_write & rd_par_err);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign rsp_valid = rsp_q.valid;
  assign rsp_rdata = rsp_q.data;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_param_data_memory.sv
// Self-checking bench for param_data_memory (DATA_W=8, ADDR_W=4, DEPTH=12).
// A transaction-level model tracks the memory contents, remaining clear cycles and the
// expected response; a negedge process compares all outputs against it every cycle.
module tb_param_data_memory;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned DP = 12;
`ifdef DMEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_req = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          err_inject = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_done;

  param_data_memory #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .err_inject (err_inject),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  int            left;          // clear cycles still to run; 0 means serving requests
  logic [DW-1:0] mm [DP];
  bit            pf [DP];       // word was written with err_inject
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic          exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_wipe();
    for (int i = 0; i < DP; i++) begin
      mm[i] = '0;
      pf[i] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    left      = DP;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_err   = 1'b0;
    model_wipe();
  endfunction

  // Effect of one clock edge with the inputs currently driven.
  function automatic void model_edge();
    bit acc;
    int a;
    if (rst) begin
      model_reset();
      return;
    end
    acc       = (left == 0) && req_valid && !clear_req;
    exp_valid = acc;
    if (acc) begin
      a = int'(req_addr);
      if (a >= DP) begin
        exp_data = req_write ? req_wdata : '0;
        exp_err  = 1'b1;
      end else if (req_write) begin
        exp_data = req_wdata;
        exp_err  = 1'b0;
        mm[a]    = req_wdata;
        pf[a]    = err_inject;
      end else begin
        exp_data = mm[a];
        exp_err  = PAR_ON && pf[a];
      end
    end
    if (clear_req) begin
      left = DP;
      model_wipe();
    end else if (left > 0) begin
      left--;
    end
  endfunction

  task automatic step(input bit r, input bit c, input bit v, input bit w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input bit inj);
    rst        = r;
    clear_req  = c;
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    err_inject = inj;
    if (r) model_reset();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit inj);
    step(1'b0, 1'b0, 1'b1, 1'b1, a, d, inj);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b0, 1'b1, 1'b0, a, '0, 1'b0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      idle();
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'((left == 0) && !clear_req));
      chk("init_done", 32'(init_done), 32'(left == 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    end
  end

  initial begin
    int n;
    model_reset();
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Clear after reset lasts exactly DEPTH cycles.
    wait_ready(n);
    chk("clear_len_reset", n, 12);
    rd(4'd5);
    chk("rd5_data", 32'(rsp_rdata), 32'h00);
    chk("rd5_err", 32'(rsp_err), 0);

    // Write then read-after-write.
    wr(4'd3, 8'hA5, 1'b0);
    chk("wr3_echo", 32'(rsp_rdata), 32'hA5);
    rd(4'd3);
    chk("raw3_valid", 32'(rsp_valid), 1);
    chk("raw3_data", 32'(rsp_rdata), 32'hA5);
    chk("raw3_err", 32'(rsp_err), 0);

    // Out of range.
    wr(4'd13, 8'h77, 1'b0);
    chk("oor_wr_err", 32'(rsp_err), 1);
    rd(4'd13);
    chk("oor_rd_data", 32'(rsp_rdata), 32'h00);
    chk("oor_rd_err", 32'(rsp_err), 1);
    rd(4'd11);
    chk("rd11_data", 32'(rsp_rdata), 32'h00);
    chk("rd11_err", 32'(rsp_err), 0);

    // clear_req blocks a same-cycle write; in-flight read response completes.
    wr(4'd7, 8'h3C, 1'b0);
    rd(4'd7);
    chk("inflight_rd7", 32'(rsp_rdata), 32'h3C);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 8'h55, 1'b0);
    chk("clr_wr_blocked", 32'(rsp_valid), 0);
    chk("clr_hold_data", 32'(rsp_rdata), 32'h3C);
    wait_ready(n);
    chk("clear_len_req", n, 12);
    rd(4'd7);
    chk("rd7_cleared", 32'(rsp_rdata), 32'h00);
    rd(4'd2);
    chk("rd2_not_written", 32'(rsp_rdata), 32'h00);

    // clear_req during CLEAR restarts the count.
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (5) idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    wait_ready(n);
    chk("clear_len_restart", n, 12);

    // Reset during a read discards the response.
    wr(4'd3, 8'h5A, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, '0, 1'b0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
    wait_ready(n);
    chk("clear_len_rst", n, 12);
    rd(4'd3);
    chk("rd3_after_rst", 32'(rsp_rdata), 32'h00);

    // Parity injection.
    wr(4'd1, 8'h81, 1'b1);
    rd(4'd1);
    chk("par_rd_data", 32'(rsp_rdata), 32'h81);
    chk("par_rd_err", 32'(rsp_err), 32'(PAR_ON));
    wr(4'd1, 8'h81, 1'b0);
    rd(4'd1);
    chk("par_clean_err", 32'(rsp_err), 0);

    // Back-to-back burst, checked by the model every cycle.
    for (int i = 0; i < 12; i++) wr(AW'(i), DW'(i * 17 + 3), 1'b0);
    for (int i = 0; i < 16; i++) rd(AW'(i));
    chk("burst_last_err", 32'(rsp_err), 1);
    rd(4'd10);
    chk("burst_rd10", 32'(rsp_rdata), 32'hAD);
    for (int i = 0; i < 6; i++) begin
      wr(AW'(i * 2), DW'(8'hF0 ^ i), 1'b0);
      rd(AW'(i * 2));
    end
    idle();
    idle();
    chk("idle_no_rsp", 32'(rsp_valid), 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_data_memory.md
Name: param_data_memory

Overview:
Parametrised single-port data memory for the 8-bit processor, successor to the fixed 16-entry data RAM. Adds generic width/depth, a valid/ready request port, a registered read with a fixed one-cycle latency, and a hardware clear sequencer that zeroes the array after reset or on request. Out-of-range accesses are flagged. Sits between the load/store unit and the data bus.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of words implemented; must satisfy 1 <= DEPTH <= 2**ADDR_W

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
clear_req  in  1  pulse: restart the clear sequence
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data, or echoed write data
rsp_err  out  1  error qualifier, valid with rsp_valid
err_inject  in  1  test hook: corrupts the stored parity bit on write (used only with the optional feature)
init_done  out  1  high while in READY

Behaviour:
- Reset (async): state=CLEAR, clr_ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
- CLEAR state:
  - Writes 0 to mem[clr_ptr] each cycle and increments clr_ptr.
  - On clr_ptr==DEPTH-1, moves to READY the next cycle. Clear takes exactly DEPTH cycles.
  - req_ready=0 throughout.
- READY state:
  - req_ready = ~clear_req (combinational).
  - init_done=1.
- clear_req handling:
  - clear_req=1 in READY: next state CLEAR, clr_ptr=0. A request presented in the same cycle is not accepted.
  - clear_req during CLEAR restarts clr_ptr at 0.
  - An in-flight response (accepted in the previous cycle) still completes.
- Accepted write:
  - Write with req_addr<DEPTH: mem[addr]<=wdata at that posedge.
  - Next cycle: rsp_valid=1, rsp_rdata=wdata, rsp_err=0.
- Accepted read:
  - Next cycle: rsp_valid=1, rsp_rdata=mem[addr] (value before any same-edge write), rsp_err=0.
- Out of range (req_addr>=DEPTH):
  - Write is dropped; read returns 0.
  - rsp_err=1 with the response.
- Cycle rules:
  - Exactly one rsp_valid pulse per accepted request, no backpressure. Back-to-back requests every cycle give back-to-back responses.
  - Read of address A in the cycle after a write to A returns the new data.
  - When no request was accepted, rsp_valid=0; rsp_rdata and rsp_err hold their last values.
- Reset mid-sequence: CLEAR restarts from 0, and any pending response is discarded (rsp_valid=0).

Optional Feature:
DMEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed from wdata on write (0 for cleared words).
  - If err_inject=1 on an accepted write, the inverted parity bit is stored.
  - On read, a parity mismatch sets rsp_err=1; rsp_rdata still returns the stored data.
- Not defined: no parity storage; err_inject is ignored; rsp_err reports only out-of-range accesses.

Decomposition:
- Package dmem_pkg holds:
  - state enum (CLEAR, READY)
  - response struct typedef {valid, data, err}
  - parity helper function
- One natural sub-module: dmem_clear_seq (clr_ptr counter plus CLEAR/READY FSM, outputs clear write enable/address and init_done).
- Array, request decode and response register stay in the top module.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=4, DEPTH=12.
- Release rst -> req_ready=0 and init_done=0 for exactly 12 cycles, then both 1; a read of addr 5 returns 0x00, rsp_err=0.
- Write 0xA5 to addr 3, then read addr 3 the next cycle -> first response rsp_rdata=0xA5; second response the next cycle rsp_rdata=0xA5, rsp_err=0.
- Write 0x77 to addr 13 -> rsp_err=1. Then read addr 13 -> rsp_rdata=0x00, rsp_err=1. Read addr 11 is unchanged.
- Write 0x3C to addr 7, then pulse clear_req together with a write to addr 2 -> the write is not accepted; 12 cycles of CLEAR follow; a read of addr 7 then returns 0x00.
- Assert rst during a read of addr 3 -> rsp_valid stays 0 and CLEAR restarts from clr_ptr 0.
- With DMEM_PARITY_EN: write 0x81 with err_inject=1 to addr 1, then read addr 1 -> rsp_rdata=0x81, rsp_err=1. Without the macro the same sequence gives rsp_err=0.
